// File: rtl/imem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_load_ctrl
// Brief    : Byte-serial loader for the instruction RAM; owns the RAM port and
//            holds the CPU in reset until a load completes.
// Revision : 1.0
// ============================================================================
module imem_load_ctrl #(
  parameter int ADDR_W = 7,
  parameter int SYNC_N = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en_i,
  input  logic              byte_stb_i,
  input  logic [7:0]        byte_in_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic              cpu_rst_n_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              loading_o,
  output logic              overflow_o,
  output logic [ADDR_W:0]   word_count_o
);

  localparam logic [1:0] c_halt  = 2'd0;
  localparam logic [1:0] c_load  = 2'd1;
  localparam logic [1:0] c_write = 2'd2;
  localparam logic [1:0] c_run   = 2'd3;
  localparam logic [ADDR_W:0] c_one = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [SYNC_N-1:0] load_sync_q, stb_sync_q;
  logic              stb_prev_q;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              overflow_q, overflow_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              pend_q, pend_d;
  logic [7:0]        pend_byte_q, pend_byte_d;

  logic       load_s, byte_edge, edge_eff, full, accept, entering;
  logic [7:0] byte_eff;

  assign load_s    = load_sync_q[SYNC_N-1];
  assign byte_edge = stb_sync_q[SYNC_N-1] & ~stb_prev_q;
  // A strobe that lands in WRITE is parked and replayed on the next LOAD cycle
  assign edge_eff  = byte_edge | pend_q;
  assign byte_eff  = pend_q ? pend_byte_q : byte_in_i;
  assign full      = word_count_q[ADDR_W];
  assign accept    = (state_q == c_load) && edge_eff && !full;
  assign entering  = ((state_q == c_halt) || (state_q == c_run)) && (state_d == c_load);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= c_halt;
      load_sync_q  <= '0;
      stb_sync_q   <= '0;
      stb_prev_q   <= 1'b0;
      byte_cnt_q   <= 2'd0;
      word_q       <= 32'd0;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
      cpu_rst_n_q  <= 1'b0;
      pend_q       <= 1'b0;
      pend_byte_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      load_sync_q  <= {load_sync_q[SYNC_N-2:0], load_en_i};
      stb_sync_q   <= {stb_sync_q[SYNC_N-2:0], byte_stb_i};
      stb_prev_q   <= stb_sync_q[SYNC_N-1];
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      word_count_q <= word_count_d;
      overflow_q   <= overflow_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      pend_q       <= pend_d;
      pend_byte_q  <= pend_byte_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_halt:  if (load_s) state_d = c_load;
      c_load: begin
        if (accept && (byte_cnt_q == 2'd3)) begin
          state_d = c_write;
        end else if (!load_s) begin
          state_d = (accept || (byte_cnt_q != 2'd0)) ? c_write : c_run;
        end
      end
      c_write: state_d = load_s ? c_load : c_run;
      c_run:   if (load_s) state_d = c_load;
      default: state_d = c_halt;
    endcase
  end

  always_comb begin
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    word_count_d = word_count_q;
    overflow_d   = overflow_q;
    pend_d       = 1'b0;
    pend_byte_d  = pend_byte_q;
    cpu_rst_n_d  = (state_d == c_run);
    if (entering) begin
      byte_cnt_d   = 2'd0;
      word_d       = 32'd0;
      word_count_d = '0;
      overflow_d   = 1'b0;
    end
    if (accept) begin
      word_d[{byte_cnt_q, 3'b000} +: 8] = byte_eff;
      byte_cnt_d = byte_cnt_q + 2'd1;
    end
    if ((state_q == c_load) && edge_eff && full) begin
      overflow_d = 1'b1;
    end
    if (state_q == c_write) begin
      word_count_d = word_count_q + c_one;
      byte_cnt_d   = 2'd0;
      word_d       = 32'd0;
      if (byte_edge) begin
        pend_d      = 1'b1;
        pend_byte_d = byte_in_i;
      end
    end
  end

  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = 32'd0;
    loading_o   = 1'b0;
    case (state_q)
      c_load:  loading_o = 1'b1;
      c_write: begin
        loading_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = word_count_q[ADDR_W-1:0];
        mem_wdata_o = word_q;
      end
      c_run:   mem_addr_o = cpu_addr_i;
      default: mem_addr_o = '0;
    endcase
  end

  assign cpu_rst_n_o  = cpu_rst_n_q;
  assign overflow_o   = overflow_q;
  assign word_count_o = word_count_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_load_ctrl
// Brief    : Scoreboard bench for imem_load_ctrl with a byte-list reference model.
// Revision : 1.0
// ============================================================================
module tb_imem_load_ctrl;

  localparam int ADDR_W = 7;
  localparam int SYNC_N = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_en, byte_stb;
  logic [7:0]        byte_in;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_rst_n, mem_we, loading, overflow;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   word_count;

  int checks = 0;
  int errors = 0;
  logic [ADDR_W+31:0] exp_q[$];
  logic [7:0]         preset_q[$];

  imem_load_ctrl #(.ADDR_W(ADDR_W), .SYNC_N(SYNC_N)) dut (
    .clk(clk), .rst_n(rst_n), .load_en_i(load_en), .byte_stb_i(byte_stb),
    .byte_in_i(byte_in), .cpu_addr_i(cpu_addr), .cpu_rst_n_o(cpu_rst_n),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .loading_o(loading), .overflow_o(overflow), .word_count_o(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every RAM write must match the next expected (addr, data) pair
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {mem_addr, mem_wdata}, 64'hDEAD);
      end else begin
        logic [ADDR_W+31:0] e;
        e = exp_q.pop_front();
        chk("write_addr", mem_addr, e[ADDR_W+31:32]);
        chk("write_data", mem_wdata, e[31:0]);
        chk("cpu_held_in_write", cpu_rst_n, 0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit drop_load);
    byte_in  = b;
    byte_stb = 1'b1;
    if (drop_load) load_en = 1'b0;
    repeat (6) @(negedge clk);
    byte_stb = 1'b0;
    repeat ($urandom_range(3, 5)) @(negedge clk);
  endtask

  // One complete load: bytes in, load_en dropped, CPU released
  task automatic session(input int n, input bit simul);
    logic [7:0] b[$];
    int nw, mid;
    logic [31:0] w;
    for (int i = 0; i < n; i++)
      b.push_back((preset_q.size() > 0) ? preset_q.pop_front() : 8'($urandom));
    nw = (n + 3) / 4;
    if (nw > DEPTH) nw = DEPTH;
    for (int k = 0; k < nw; k++) begin
      w = 32'd0;
      for (int j = 0; j < 4; j++)
        if (4 * k + j < n) w[8*j +: 8] = b[4*k+j];
      exp_q.push_back({ADDR_W'(k), w});
    end
    load_en = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < n; i++) send_byte(b[i], simul && (i == n - 1));
    if (!simul && ((n % 4 == 0) || n > 4 * DEPTH)) begin
      mid = n / 4;
      if (mid > DEPTH) mid = DEPTH;
      #1;
      chk("mid_word_count", word_count, mid);
      chk("mid_cpu_held", cpu_rst_n, 0);
      chk("mid_loading", loading, 1);
      chk("mid_overflow", overflow, (n > 4 * DEPTH));
    end
    load_en = 1'b0;
    repeat (8) @(negedge clk);
    cpu_addr = ADDR_W'($urandom);
    #1;
    chk("run_cpu_released", cpu_rst_n, 1);
    chk("run_loading", loading, 0);
    chk("run_word_count", word_count, nw);
    chk("run_overflow", overflow, (n > 4 * DEPTH));
    chk("run_mem_addr_mux", mem_addr, cpu_addr);
    chk("run_pending_writes", exp_q.size(), 0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; load_en = 1'b0; byte_stb = 1'b0; byte_in = 8'd0; cpu_addr = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_cpu_rst_n", cpu_rst_n, 0);
    chk("reset_mem_we", mem_we, 0);
    chk("reset_word_count", word_count, 0);
    chk("reset_outputs", {loading, overflow, mem_addr, mem_wdata}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cpu_addr = ADDR_W'($urandom);
      #1;
      chk("halt_idle", {cpu_rst_n, mem_we, loading, mem_addr}, 0);
    end

    preset_q = '{8'h78, 8'h56, 8'h34, 8'h12};
    session(4, 1'b0);

    preset_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB};
    session(6, 1'b0);
    @(negedge clk);
    cpu_addr = 5;
    #1;
    chk("cpu_addr_follow", mem_addr, 5);

    for (int s = 0; s < 6; s++) session($urandom_range(0, 13), 1'($urandom));
    session(5, 1'b1);
    session(8, 1'b1);

    session(4 * DEPTH + 1, 1'b0);

    @(negedge clk);
    load_en = 1'b1;
    k = 0;
    while (cpu_rst_n === 1'b1 && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("reload_hold_latency", (k <= SYNC_N + 1) && (cpu_rst_n === 1'b0), 1);
    chk("reload_word_count", word_count, 0);
    chk("reload_overflow", overflow, 0);
    session(3, 1'b0);

    load_en = 1'b1;
    repeat (3) @(negedge clk);
    send_byte(8'hC3, 1'b0);
    send_byte(8'h3C, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midload_reset_outputs",
        {cpu_rst_n, mem_we, loading, overflow, word_count, mem_addr, mem_wdata}, 0);
    load_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("midload_reset_halt", {cpu_rst_n, loading}, 0);
    chk("midload_no_write", exp_q.size(), 0);

    session(7, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
